turfio_trig_collect: RTL and testbench
======================================

TURFIO_TRIG_COLLECT -- requirements
Module: turfio_trig_collect

Interface
REQ-001 SHALL have parameter NUM_LANE, default 8, number of CIN trigger lanes from one TURFIO port; legal values 2..8.
REQ-002 SHALL have port sysclk_i, input, 1 bit: the only clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n_i, input, 1 bit: reset, asynchronous assert, active-low.
REQ-004 SHALL have port trigger_i, input, 16*NUM_LANE bits: lane j trigger word at [16*j +: 16], in the sysclk domain.
REQ-005 SHALL have port valid_i, input, NUM_LANE bits: lane j trigger word valid this cycle.
REQ-006 SHALL have port enable_i, input, 1 bit: capture enable.
REQ-007 SHALL have port clear_i, input, 1 bit: synchronous clear of error status.
REQ-008 SHALL have port m_tdata_o, output, 24 bits: [15:0] trigger word, [18:16] lane index, [23:19] zero.
REQ-009 SHALL have port m_tvalid_o, output, 1 bit: output word valid.
REQ-010 SHALL have port m_tready_i, input, 1 bit: downstream accepts the word.
REQ-011 SHALL have port overflow_o, output, NUM_LANE bits: sticky per-lane drop flags.
REQ-012 SHALL have port drop_count_o, output, 16 bits: total dropped words.

Function
REQ-013 SHALL hold one entry (data + hold_valid) per lane, and one output register.
REQ-014 SHALL, with enable_i high and valid_i[j] high, load trigger_i lane j into hold j if hold j is empty or is transferred to the output register in the same cycle.
REQ-015 SHALL otherwise drop the word, set overflow_o[j], and increment drop_count_o by the number of lanes dropping that cycle, saturating at 0xFFFF.
REQ-016 SHALL ignore valid_i entirely while enable_i is low: no capture, no drop; held entries still drain.
REQ-017 SHALL load the output register when it is empty or accepted this cycle (m_tvalid_o && m_tready_i) and any hold is valid.
REQ-018 SHALL pick the round-robin winner as the first valid lane at or after pointer rr_ptr, wrapping modulo NUM_LANE, then set rr_ptr to winner+1 modulo NUM_LANE; rr_ptr is unchanged if there is no winner.
REQ-019 SHALL have a latency of 2 cycles when idle: valid_i sampled at edge k gives m_tvalid_o high after edge k+1.
REQ-020 SHALL hold m_tdata_o stable while m_tvalid_o is high and m_tready_i is low.
REQ-021 SHALL, when m_tvalid_o is high with m_tready_i high and no hold is valid, drive m_tvalid_o low after the edge.
REQ-022 SHALL sustain one word per cycle when m_tready_i is held high.
REQ-023 SHALL, on clear_i, zero overflow_o and drop_count_o on the next edge.
REQ-024 SHALL let a simultaneous drop win over clear_i: the flag stays set and the count becomes the number of lanes dropped that cycle.
REQ-025 SHALL not affect held or output data through clear_i.

Reset
REQ-026 SHALL, while rst_n_i is low, force m_tvalid_o=0, m_tdata_o=0, overflow_o=0, drop_count_o=0, all hold_valid=0, rr_ptr=0.
REQ-027 SHALL discard any in-flight word on reset mid-operation; the first valid_i after deassertion is handled per REQ-014.

Configuration
REQ-028 SHALL implement drop_count_o counting (REQ-015, REQ-023, REQ-024) only when macro TURFIO_TRIG_COLLECT_STATS_EN is defined.
REQ-029 SHALL, when TURFIO_TRIG_COLLECT_STATS_EN is undefined, drive drop_count_o constant 0 with no counter logic; overflow_o is unchanged.

Verification
REQ-030 SHALL cover: lane 3 word 0x1234 pulse with m_tready_i=1 -> m_tdata_o=0x031234, m_tvalid_o high exactly 2 edges later for 1 cycle.
REQ-031 SHALL cover: all 8 lanes valid in one cycle with data 0xA000+j and tready=1 -> 8 consecutive words, lanes 0..7 in order, no overflow.
REQ-032 SHALL cover: m_tready_i=0 with lane 5 pulsed 3 times -> 1 in hold, 1 in output, 1 dropped; overflow_o=0x20, drop_count_o=1; clear_i then gives 0 and 0.
REQ-033 SHALL cover: drop_count_o at 0xFFFF plus further drops -> stays 0xFFFF; clear_i together with a lane 0 drop -> overflow_o[0]=1, drop_count_o=1.
REQ-034 SHALL cover: enable_i=0 with valid_i=0xFF -> no output and no overflow; rst_n_i low mid-burst -> all outputs 0 immediately, rr_ptr restarts at lane 0.
REQ-035 SHALL cover: build without TURFIO_TRIG_COLLECT_STATS_EN and force overflows -> overflow_o set, drop_count_o stays 0.

Source files
------------

// File: rtl/turfio_trig_collect.sv
// Collects per-lane CIN trigger words into a single round-robin AXI-Stream-style output.
// Optional drop counter is built only when TURFIO_TRIG_COLLECT_STATS_EN is defined.
module turfio_trig_collect #(
  parameter int NUM_LANE = 8
) (
  input  logic                    sysclk_i,
  input  logic                    rst_n_i,
  input  logic [16*NUM_LANE-1:0]  trigger_i,
  input  logic [NUM_LANE-1:0]     valid_i,
  input  logic                    enable_i,
  input  logic                    clear_i,
  output logic [23:0]             m_tdata_o,
  output logic                    m_tvalid_o,
  input  logic                    m_tready_i,
  output logic [NUM_LANE-1:0]     overflow_o,
  output logic [15:0]             drop_count_o
);

  logic [NUM_LANE-1:0][15:0] hold_q;
  logic [NUM_LANE-1:0]       hold_vld_q, hold_vld_d;
  logic [NUM_LANE-1:0]       cap, drop;
  logic [2:0]                rr_q, rr_d, win;
  logic [15:0]               win_data;
  logic                      win_vld, out_load;
  logic                      tvalid_q, tvalid_d;
  logic [23:0]               tdata_q, tdata_d;
  logic [NUM_LANE-1:0]       ovf_q, ovf_d;

  // First valid hold at or after rr_q, wrapping.
  always_comb begin
    int idx;
    idx      = 0;
    win      = '0;
    win_vld  = 1'b0;
    win_data = '0;
    for (int k = 0; k < NUM_LANE; k++) begin
      idx = (int'(rr_q) + k) % NUM_LANE;
      if (!win_vld && hold_vld_q[idx]) begin
        win_vld  = 1'b1;
        win      = 3'(idx);
        win_data = hold_q[idx];
      end
    end
  end

  assign out_load = win_vld && (!tvalid_q || m_tready_i);

  // A hold that is moving to the output this cycle can take a new word.
  always_comb begin
    hold_vld_d = hold_vld_q;
    cap        = '0;
    drop       = '0;
    for (int j = 0; j < NUM_LANE; j++) begin
      if (out_load && win == 3'(j))
        hold_vld_d[j] = 1'b0;
      if (enable_i && valid_i[j]) begin
        if (!hold_vld_d[j]) begin
          cap[j]        = 1'b1;
          hold_vld_d[j] = 1'b1;
        end else begin
          drop[j] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    rr_d     = rr_q;
    if (out_load) begin
      tvalid_d = 1'b1;
      tdata_d  = {5'b0, win, win_data};
      rr_d     = (win == 3'(NUM_LANE - 1)) ? 3'd0 : win + 3'd1;
    end else if (m_tready_i) begin
      tvalid_d = 1'b0;
    end
    // A drop in the same cycle as clear survives the clear.
    ovf_d = clear_i ? drop : (ovf_q | drop);
  end

  always_ff @(posedge sysclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hold_q     <= '0;
      hold_vld_q <= '0;
      rr_q       <= '0;
      tvalid_q   <= 1'b0;
      tdata_q    <= '0;
      ovf_q      <= '0;
    end else begin
      for (int j = 0; j < NUM_LANE; j++)
        if (cap[j]) hold_q[j] <= trigger_i[16*j +: 16];
      hold_vld_q <= hold_vld_d;
      rr_q       <= rr_d;
      tvalid_q   <= tvalid_d;
      tdata_q    <= tdata_d;
      ovf_q      <= ovf_d;
    end
  end

  assign m_tvalid_o = tvalid_q;
  assign m_tdata_o  = tdata_q;
  assign overflow_o = ovf_q;

`ifdef TURFIO_TRIG_COLLECT_STATS_EN
  logic [15:0] cnt_q, cnt_d;
  logic [16:0] cnt_sum;
  logic [3:0]  ndrop;

  always_comb begin
    ndrop = '0;
    for (int j = 0; j < NUM_LANE; j++)
      ndrop = ndrop + 4'(drop[j]);
    cnt_sum = (clear_i ? 17'd0 : {1'b0, cnt_q}) + {13'd0, ndrop};
    cnt_d   = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end

  always_ff @(posedge sysclk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign drop_count_o = cnt_q;
`else
  assign drop_count_o = '0;
`endif

endmodule

// File: tb/tb_turfio_trig_collect.sv
// Randomized + directed bench for turfio_trig_collect with a slot-level reference model.
module tb_turfio_trig_collect;
  localparam int NL = 8;
`ifdef TURFIO_TRIG_COLLECT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [16*NL-1:0] trig;
  logic [NL-1:0] vld;
  logic          en, clr, rdy;
  logic [23:0]   tdata;
  logic          tvalid;
  logic [NL-1:0] ovf;
  logic [15:0]   dcnt;

  int tests = 0;
  int fails = 0;

  // Reference model state: one slot per lane plus the output slot.
  bit          m_hv[NL];
  logic [15:0] m_hd[NL];
  bit          m_ov;
  logic [23:0] m_od;
  int          m_rr;
  logic [NL-1:0] m_ovf;
  int          m_cnt;

  turfio_trig_collect #(.NUM_LANE(NL)) dut (
    .sysclk_i(clk), .rst_n_i(rst_n), .trigger_i(trig), .valid_i(vld),
    .enable_i(en), .clear_i(clr), .m_tdata_o(tdata), .m_tvalid_o(tvalid),
    .m_tready_i(rdy), .overflow_o(ovf), .drop_count_o(dcnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    vld = '0; en = 1'b1; clr = 1'b0; rdy = 1'b1; trig = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic set_lane(input int j, input logic [15:0] d);
    trig[16*j +: 16] = d;
  endtask

  task automatic model_reset();
    for (int j = 0; j < NL; j++) begin m_hv[j] = 0; m_hd[j] = '0; end
    m_ov = 0; m_od = '0; m_rr = 0; m_ovf = '0; m_cnt = 0;
  endtask

  // One clock of behaviour, applied to the inputs present at the edge.
  task automatic model_step();
    bit any, load;
    int w, nd;
    logic [NL-1:0] dmask;
    any = 0;
    for (int j = 0; j < NL; j++) any |= m_hv[j];
    load = any && (!m_ov || rdy);
    if (load) begin
      w = -1;
      for (int k = 0; k < NL; k++)
        if (w < 0 && m_hv[(m_rr + k) % NL]) w = (m_rr + k) % NL;
      m_ov = 1;
      m_od = {5'b0, 3'(w), m_hd[w]};
      m_hv[w] = 0;
      m_rr = (w + 1) % NL;
    end else if (rdy) begin
      m_ov = 0;
    end
    nd = 0; dmask = '0;
    if (en) begin
      for (int j = 0; j < NL; j++) begin
        if (vld[j]) begin
          if (!m_hv[j]) begin m_hv[j] = 1; m_hd[j] = trig[16*j +: 16]; end
          else begin nd++; dmask[j] = 1'b1; end
        end
      end
    end
    if (clr) begin m_ovf = dmask; m_cnt = nd; end
    else begin
      m_ovf |= dmask;
      m_cnt = (m_cnt + nd > 65535) ? 65535 : m_cnt + nd;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    vld = '0; en = 1'b1; clr = 1'b0; rdy = 1'b1; trig = '0;
    @(negedge clk);
    tests++; if (tvalid !== 1'b0) begin fails++; $display("FAIL reset_tvalid got %b exp 0", tvalid); end
    tests++; if (tdata !== 24'h0) begin fails++; $display("FAIL reset_tdata got %h exp 000000", tdata); end
    tests++; if (ovf !== 8'h0) begin fails++; $display("FAIL reset_ovf got %h exp 00", ovf); end
    tests++; if (dcnt !== 16'h0) begin fails++; $display("FAIL reset_dcnt got %h exp 0000", dcnt); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    apply_reset();
    set_lane(3, 16'h1234); vld = 8'h08;
    tick(); vld = '0;
    tests++; if (tvalid !== 1'b0) begin fails++; $display("FAIL single_early got %b exp 0", tvalid); end
    tick();
    tests++; if (tvalid !== 1'b1 || tdata !== 24'h031234) begin
      fails++; $display("FAIL single_word got v=%b d=%h exp v=1 d=031234", tvalid, tdata); end
    tick();
    tests++; if (tvalid !== 1'b0) begin fails++; $display("FAIL single_len got %b exp 0", tvalid); end
  endtask

  task automatic test_all_lanes();
    apply_reset();
    for (int j = 0; j < NL; j++) set_lane(j, 16'hA000 + 16'(j));
    vld = 8'hFF;
    tick(); vld = '0;
    for (int j = 0; j < NL; j++) begin
      tick();
      tests++; if (tvalid !== 1'b1 || tdata !== {5'b0, 3'(j), 16'hA000 + 16'(j)}) begin
        fails++; $display("FAIL all_lanes_%0d got v=%b d=%h exp v=1 d=%h", j, tvalid, tdata,
                          {5'b0, 3'(j), 16'hA000 + 16'(j)}); end
    end
    tick();
    tests++; if (tvalid !== 1'b0 || ovf !== 8'h0) begin
      fails++; $display("FAIL all_lanes_end got v=%b ovf=%h exp v=0 ovf=00", tvalid, ovf); end
  endtask

  task automatic test_backpressure();
    apply_reset();
    rdy = 1'b0;
    vld = 8'h20; set_lane(5, 16'h1111); tick();
    set_lane(5, 16'h2222); tick();
    set_lane(5, 16'h3333); tick();
    vld = '0;
    tests++; if (tvalid !== 1'b1 || tdata !== 24'h051111) begin
      fails++; $display("FAIL bp_hold got v=%b d=%h exp v=1 d=051111", tvalid, tdata); end
    tests++; if (ovf !== 8'h20) begin fails++; $display("FAIL bp_ovf got %h exp 20", ovf); end
    tests++; if (dcnt !== (STATS ? 16'd1 : 16'd0)) begin
      fails++; $display("FAIL bp_dcnt got %0d exp %0d", dcnt, STATS ? 1 : 0); end
    clr = 1'b1; tick(); clr = 1'b0;
    tests++; if (ovf !== 8'h0 || dcnt !== 16'h0) begin
      fails++; $display("FAIL bp_clear got ovf=%h cnt=%0d exp 00 0", ovf, dcnt); end
    tests++; if (tvalid !== 1'b1 || tdata !== 24'h051111) begin
      fails++; $display("FAIL bp_clear_data got v=%b d=%h exp v=1 d=051111", tvalid, tdata); end
    rdy = 1'b1; tick();
    tests++; if (tvalid !== 1'b1 || tdata !== 24'h052222) begin
      fails++; $display("FAIL bp_drain got v=%b d=%h exp v=1 d=052222", tvalid, tdata); end
    tick();
    tests++; if (tvalid !== 1'b0) begin fails++; $display("FAIL bp_empty got %b exp 0", tvalid); end
  endtask

  task automatic test_saturate();
    apply_reset();
    rdy = 1'b0; vld = 8'hFF;
    repeat (8300) tick();
    vld = '0;
    tests++; if (dcnt !== (STATS ? 16'hFFFF : 16'h0) || ovf !== 8'hFF) begin
      fails++; $display("FAIL sat_reach got cnt=%h ovf=%h exp cnt=%h ovf=ff", dcnt, ovf,
                        STATS ? 16'hFFFF : 16'h0); end
    vld = 8'hFF; tick(); vld = '0;
    tests++; if (dcnt !== (STATS ? 16'hFFFF : 16'h0)) begin
      fails++; $display("FAIL sat_hold got %h exp %h", dcnt, STATS ? 16'hFFFF : 16'h0); end
    vld = 8'h01; clr = 1'b1; tick(); vld = '0; clr = 1'b0;
    tests++; if (ovf !== 8'h01 || dcnt !== (STATS ? 16'd1 : 16'd0)) begin
      fails++; $display("FAIL sat_clr_drop got ovf=%h cnt=%0d exp ovf=01 cnt=%0d", ovf, dcnt,
                        STATS ? 1 : 0); end
  endtask

  task automatic test_enable();
    apply_reset();
    en = 1'b0; vld = 8'hFF; trig = {NL{16'hBEEF}};
    repeat (6) begin
      tick();
      tests++; if (tvalid !== 1'b0) begin fails++; $display("FAIL en_tvalid got %b exp 0", tvalid); end
    end
    tests++; if (ovf !== 8'h0) begin fails++; $display("FAIL en_ovf got %h exp 00", ovf); end
    vld = '0; en = 1'b1;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int j = 0; j < NL; j++) set_lane(j, 16'hA000 + 16'(j));
    rdy = 1'b0; vld = 8'hFF; tick(); tick(); vld = '0; rdy = 1'b1; tick();
    tests++; if (tvalid !== 1'b1 || ovf === 8'h0) begin
      fails++; $display("FAIL mid_busy got v=%b ovf=%h exp v=1 ovf!=00", tvalid, ovf); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (tvalid !== 1'b0 || tdata !== 24'h0 || ovf !== 8'h0 || dcnt !== 16'h0) begin
      fails++; $display("FAIL mid_reset got v=%b d=%h ovf=%h cnt=%h exp all 0", tvalid, tdata, ovf, dcnt); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vld = 8'hFF; tick(); vld = '0;
    for (int j = 0; j < 2; j++) begin
      tick();
      tests++; if (tvalid !== 1'b1 || tdata !== {5'b0, 3'(j), 16'hA000 + 16'(j)}) begin
        fails++; $display("FAIL mid_restart_%0d got v=%b d=%h exp v=1 d=%h", j, tvalid, tdata,
                          {5'b0, 3'(j), 16'hA000 + 16'(j)}); end
    end
  endtask

  task automatic test_random();
    apply_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      en  = ($urandom_range(0, 7) != 0);
      rdy = ($urandom_range(0, 9) < 6);
      clr = ($urandom_range(0, 49) == 0);
      vld = ($urandom_range(0, 3) == 0) ? 8'($urandom) : (8'($urandom) & 8'($urandom) & 8'($urandom));
      for (int j = 0; j < NL; j++) set_lane(j, 16'($urandom));
      @(posedge clk);
      model_step();
      @(negedge clk);
      tests++; if (tvalid !== m_ov) begin
        fails++; $display("FAIL rnd_tvalid c=%0d got %b exp %b", c, tvalid, m_ov); end
      if (m_ov) begin
        tests++; if (tdata !== m_od) begin
          fails++; $display("FAIL rnd_tdata c=%0d got %h exp %h", c, tdata, m_od); end
      end
      tests++; if (ovf !== m_ovf) begin
        fails++; $display("FAIL rnd_ovf c=%0d got %h exp %h", c, ovf, m_ovf); end
      tests++; if (dcnt !== (STATS ? 16'(m_cnt) : 16'h0)) begin
        fails++; $display("FAIL rnd_dcnt c=%0d got %0d exp %0d", c, dcnt, STATS ? m_cnt : 0); end
    end
    vld = '0; clr = 1'b0; rdy = 1'b1; en = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; vld = '0; en = 1'b1; clr = 1'b0; rdy = 1'b1; trig = '0;
    test_reset();
    test_single();
    test_all_lanes();
    test_backpressure();
    test_saturate();
    test_enable();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
